// File: rtl/sdram_rw_pkg.sv
// sdram_rw_pkg: shared types and helpers for the SDRAM read/write tester.
//   state_e  : tester FSM states
//   pattern(): deterministic 64-bit test word for a word index
//   DATA_W   : Avalon data width (64)
//   BE_ALL   : full byte-enable mask
package sdram_rw_pkg;

  localparam int         DATA_W = 64;
  localparam logic [7:0] BE_ALL = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_CMD,
    RD_DATA,
    FIN
  } state_e;

  // Word i of the window carries {v, ~v} with v = seed + i (32-bit wrap),
  // so a stuck or swapped half is caught as well as a wrong address.
  function automatic logic [DATA_W-1:0] pattern(input logic [31:0] seed,
                                                input logic [31:0] idx);
    logic [31:0] v;
    v = seed + idx;
    return {v, ~v};
  endfunction

endpackage

// File: rtl/sdram_rw_checker.sv
// sdram_rw_checker: registered compare of returned read beats.
//   clk, rst_n        : clock, async active-low reset
//   clear_i           : zero the results (new test accepted)
//   beat_valid_i      : a read beat belonging to the current test is present
//   rdata_i           : read data of that beat
//   beat_idx_i        : 0-based word index of the beat within the window
//   base_addr_i       : window base word address
//   err_count_o       : saturating count of mismatching words
//   first_err_addr_o  : word address of the first mismatch since clear
module sdram_rw_checker
  import sdram_rw_pkg::*;
#(
  parameter int          ADDR_W = 27,
  parameter logic [31:0] SEED   = 32'hA5A5_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              beat_valid_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [ADDR_W-1:0] beat_idx_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic [15:0]       err_count_o,
  output logic [ADDR_W-1:0] first_err_addr_o
);

  logic              mismatch;
  logic [15:0]       err_count_q;
  logic [ADDR_W-1:0] first_err_addr_q;

  assign mismatch = beat_valid_i && (rdata_i != pattern(SEED, 32'(beat_idx_i)));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q      <= '0;
      first_err_addr_q <= '0;
    end else if (clear_i) begin
      err_count_q      <= '0;
      first_err_addr_q <= '0;
    end else if (mismatch) begin
      if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
      // The count saturates rather than wrapping, so zero means "no error yet".
      if (err_count_q == 16'd0) first_err_addr_q <= base_addr_i + beat_idx_i;
    end
  end

  assign err_count_o      = err_count_q;
  assign first_err_addr_o = first_err_addr_q;

endmodule

// File: rtl/sdram_rw_tester.sv
// sdram_rw_tester: Avalon-MM burst master that writes a pattern to a window of
// HPS SDRAM, reads it back one burst at a time and counts mismatches.
//   clk_clk, reset_reset_n          : clock, async active-low reset
//   start, base_addr, num_words     : test request, sampled in IDLE
//   busy, done                      : test in progress, one-cycle end pulse
//   err_count, first_err_addr       : results, held until the next start
//   avm_*                           : Avalon-MM master port (64-bit words)
module sdram_rw_tester
  import sdram_rw_pkg::*;
#(
  parameter int          ADDR_W    = 27,
  parameter int          BURST_LEN = 8,
  parameter int          BURST_W   = 7,
  parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic [BURST_W-1:0] avm_burstcount,
  output logic              avm_write,
  output logic              avm_read,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [7:0]        avm_byteenable,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  localparam int                BL_LOG2   = $clog2(BURST_LEN);
  localparam logic [ADDR_W-1:0] BL_A      = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [BURST_W-1:0] LAST_BEAT = BURST_W'(BURST_LEN - 1);
  localparam logic [BURST_W-1:0] ONE_B     = BURST_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;          // window base
  logic [ADDR_W-1:0] bursts_q, bursts_d;      // bursts in the window
  logic [ADDR_W-1:0] burst_cnt_q, burst_cnt_d; // bursts finished in this phase
  logic [BURST_W-1:0] beat_q, beat_d;         // beat within the current burst
  logic [ADDR_W-1:0] idx_q, idx_d;            // word index within the window
  logic [ADDR_W-1:0] addr_q, addr_d;          // current burst start address
  logic              done_q, done_d;
  logic              clear;
  logic              last_burst;

  assign last_burst = (burst_cnt_q == bursts_q - ONE_A);

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    bursts_d    = bursts_q;
    burst_cnt_d = burst_cnt_q;
    beat_d      = beat_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    done_d      = 1'b0;
    clear       = 1'b0;
    avm_write   = 1'b0;
    avm_read    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          clear       = 1'b1;
          base_d      = base_addr;
          addr_d      = base_addr;
          bursts_d    = num_words >> BL_LOG2;
          burst_cnt_d = '0;
          beat_d      = '0;
          idx_d       = '0;
          state_d     = ((num_words >> BL_LOG2) != '0) ? WR : FIN;
        end
      end

      WR: begin
        avm_write = 1'b1;
        if (!avm_waitrequest) begin
          idx_d = idx_q + ONE_A;
          if (beat_q == LAST_BEAT) begin
            beat_d      = '0;
            addr_d      = addr_q + BL_A;
            burst_cnt_d = burst_cnt_q + ONE_A;
            if (last_burst) begin
              state_d     = RD_CMD;
              addr_d      = base_q;
              idx_d       = '0;
              burst_cnt_d = '0;
            end
          end else begin
            beat_d = beat_q + ONE_B;
          end
        end
      end

      RD_CMD: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) state_d = RD_DATA;
      end

      RD_DATA: begin
        if (avm_readdatavalid) begin
          idx_d = idx_q + ONE_A;
          if (beat_q == LAST_BEAT) begin
            beat_d      = '0;
            addr_d      = addr_q + BL_A;
            burst_cnt_d = burst_cnt_q + ONE_A;
            state_d     = last_burst ? FIN : RD_CMD;
          end else begin
            beat_d = beat_q + ONE_B;
          end
        end
      end

      FIN: begin
        // The final beat was compared on the edge that entered FIN, so the
        // results are already stable when done rises.
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      bursts_q    <= '0;
      burst_cnt_q <= '0;
      beat_q      <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      bursts_q    <= bursts_d;
      burst_cnt_q <= burst_cnt_d;
      beat_q      <= beat_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      done_q      <= done_d;
    end
  end

  // Strobes decode straight from the state register, so an async reset drops
  // them immediately.
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign avm_address    = addr_q;
  assign avm_burstcount = BURST_W'(BURST_LEN);
  assign avm_byteenable = BE_ALL;
  assign avm_writedata  = (state_q == WR) ? pattern(SEED, 32'(idx_q)) : '0;

  // Beats arriving outside RD_DATA (e.g. leftovers after a reset) are dropped.
  sdram_rw_checker #(
    .ADDR_W (ADDR_W),
    .SEED   (SEED)
  ) u_checker (
    .clk              (clk_clk),
    .rst_n            (reset_reset_n),
    .clear_i          (clear),
    .beat_valid_i     ((state_q == RD_DATA) && avm_readdatavalid),
    .rdata_i          (avm_readdata),
    .beat_idx_i       (idx_q),
    .base_addr_i      (base_q),
    .err_count_o      (err_count),
    .first_err_addr_o (first_err_addr)
  );

endmodule

// File: tb/tb_sdram_rw_tester.sv
// tb_sdram_rw_tester: table-driven bench with an Avalon slave model and
// scoreboard queues for write addresses, write data and read addresses.
module tb_sdram_rw_tester;

  localparam int          ADDR_W = 27;
  localparam int          BL     = 8;
  localparam logic [31:0] SEED   = 32'hA5A5_0000;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct {
    addr_t       base;
    addr_t       num;
    int          wait_pct;
    int          lat_min;
    int          lat_max;
    int          c0;
    int          c1;
    logic [15:0] exp_err;
    addr_t       exp_first;
    int          exp_bursts;
    bit          mid_start;
  } vec_t;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        start;
  addr_t       base_addr;
  addr_t       num_words;
  logic        busy, done;
  logic [15:0] err_count;
  addr_t       first_err_addr;
  addr_t       avm_address;
  logic [6:0]  avm_burstcount;
  logic        avm_write, avm_read;
  logic [63:0] avm_writedata;
  logic [7:0]  avm_byteenable;
  logic [63:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;

  sdram_rw_tester #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BL),
    .BURST_W   (7),
    .SEED      (SEED)
  ) dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .start             (start),
    .base_addr         (base_addr),
    .num_words         (num_words),
    .busy              (busy),
    .done              (done),
    .err_count         (err_count),
    .first_err_addr    (first_err_addr),
    .avm_address       (avm_address),
    .avm_burstcount    (avm_burstcount),
    .avm_write         (avm_write),
    .avm_read          (avm_read),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest)
  );

  always #5 clk_clk = ~clk_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_word(input int i);
    logic [31:0] v;
    v = SEED + 32'(i);
    return {v, ~v};
  endfunction

  // Slave configuration and scoreboard
  int          wait_pct = 0, lat_min = 1, lat_max = 1, corrupt0 = -1, corrupt1 = -1;
  addr_t       test_base = '0;
  addr_t       exp_wr_addr[$];
  addr_t       exp_rd_addr[$];
  logic [63:0] exp_wdata[$];
  logic [63:0] mem[addr_t];

  // Slave state and statistics
  int          wr_beat = 0, rd_left = 0, rd_k = 0, rd_delay = 0;
  addr_t       wr_base, rd_addr;
  int          bus_cycles = 0, wr_cycles = 0, stall_viol = 0, wr_bursts = 0, rd_bursts = 0;
  bit          prev_stall = 0, prev_wr = 0;
  addr_t       prev_addr;
  logic [63:0] prev_data;

  // Avalon slave: decides waitrequest / read beats for the coming rising edge
  // at each falling edge, then books whatever that edge will accept.
  initial begin
    addr_t       a;
    logic [63:0] d;
    int          idx;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge clk_clk);
      if (prev_stall) begin
        if ((prev_wr && (!avm_write || avm_writedata !== prev_data)) ||
            (!prev_wr && !avm_read) || avm_address !== prev_addr)
          stall_viol++;
      end
      avm_waitrequest   = ($urandom_range(0, 99) < wait_pct);
      avm_readdatavalid = 1'b0;
      if (rd_left > 0) begin
        if (rd_delay > 0) rd_delay--;
        else if ($urandom_range(0, 99) >= wait_pct) begin
          a   = rd_addr + addr_t'(rd_k);
          d   = mem.exists(a) ? mem[a] : 64'd0;
          idx = int'(addr_t'(a - test_base));
          if (idx == corrupt0 || idx == corrupt1) d = d ^ 64'h0000_0001_0000_0000;
          avm_readdata      = d;
          avm_readdatavalid = 1'b1;
          rd_k++;
          rd_left--;
        end
      end
      if (avm_write || avm_read) bus_cycles++;
      if (avm_write) wr_cycles++;
      prev_stall = (avm_write || avm_read) && avm_waitrequest;
      prev_wr    = avm_write;
      prev_addr  = avm_address;
      prev_data  = avm_writedata;
      if (avm_write && !avm_waitrequest) begin
        if (wr_beat == 0) begin
          wr_base = avm_address;
          wr_bursts++;
          check("wr_burstcount", 64'(avm_burstcount), 64'(BL));
          check("wr_byteenable", 64'(avm_byteenable), 64'hFF);
          if (exp_wr_addr.size() == 0) check("wr_addr_unexpected", 64'(avm_address), 64'h0);
          else check("wr_addr", 64'(avm_address), 64'(exp_wr_addr.pop_front()));
        end
        if (exp_wdata.size() == 0) check("wdata_unexpected", avm_writedata, 64'h0);
        else check("wdata", avm_writedata, exp_wdata.pop_front());
        mem[wr_base + addr_t'(wr_beat)] = avm_writedata;
        wr_beat = (wr_beat + 1) % BL;
      end
      if (avm_read && !avm_waitrequest) begin
        rd_bursts++;
        check("rd_one_outstanding", 64'(rd_left), 64'h0);
        check("rd_burstcount", 64'(avm_burstcount), 64'(BL));
        if (exp_rd_addr.size() == 0) check("rd_addr_unexpected", 64'(avm_address), 64'h0);
        else check("rd_addr", 64'(avm_address), 64'(exp_rd_addr.pop_front()));
        rd_addr  = avm_address;
        rd_k     = 0;
        rd_left  = BL;
        rd_delay = int'($urandom_range(lat_min, lat_max)) - 1;
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'h0);
    check({tag, "_done"}, 64'(done), 64'h0);
    check({tag, "_write"}, 64'(avm_write), 64'h0);
    check({tag, "_read"}, 64'(avm_read), 64'h0);
    check({tag, "_err_count"}, 64'(err_count), 64'h0);
    check({tag, "_first_err"}, 64'(first_err_addr), 64'h0);
    check({tag, "_address"}, 64'(avm_address), 64'h0);
    check({tag, "_writedata"}, avm_writedata, 64'h0);
    check({tag, "_burstcount"}, 64'(avm_burstcount), 64'(BL));
    check({tag, "_byteenable"}, 64'(avm_byteenable), 64'hFF);
  endtask

  task automatic run_test(input vec_t v);
    int nb, n, k, bus0, wr0, wb0, rb0;
    nb = int'(v.num) / BL;
    n  = nb * BL;
    wait_pct  = v.wait_pct;
    lat_min   = v.lat_min;
    lat_max   = v.lat_max;
    corrupt0  = v.c0;
    corrupt1  = v.c1;
    test_base = v.base;
    for (int b = 0; b < nb; b++) begin
      exp_wr_addr.push_back(v.base + addr_t'(b * BL));
      exp_rd_addr.push_back(v.base + addr_t'(b * BL));
    end
    for (int i = 0; i < n; i++) exp_wdata.push_back(model_word(i));
    bus0 = bus_cycles; wr0 = wr_cycles; wb0 = wr_bursts; rb0 = rd_bursts;
    stall_viol = 0;

    @(negedge clk_clk);
    start = 1'b1; base_addr = v.base; num_words = v.num;
    @(negedge clk_clk);
    start = 1'b0;
    k = 1;
    check("busy_after_start", 64'(busy), 64'h1);
    while (done !== 1'b1 && k < 5000) begin
      @(negedge clk_clk);
      k++;
      if (v.mid_start && k == 10) begin
        start = 1'b1; base_addr = '0; num_words = addr_t'(BL);
      end else begin
        start = 1'b0; base_addr = v.base; num_words = v.num;
      end
    end
    start = 1'b0;
    if (done !== 1'b1) begin
      check("done_timeout", 64'h0, 64'h1);
    end else begin
      check("busy_at_done", 64'(busy), 64'h0);
      if (v.exp_bursts == 0) begin
        check("done_latency", 64'(k), 64'd2);
        check("no_bus_activity", 64'(bus_cycles - bus0), 64'h0);
      end
      if (v.wait_pct == 0 && v.exp_bursts > 0)
        check("write_phase_cycles", 64'(wr_cycles - wr0), 64'(v.exp_bursts * BL));
      check("wr_bursts", 64'(wr_bursts - wb0), 64'(v.exp_bursts));
      check("rd_bursts", 64'(rd_bursts - rb0), 64'(v.exp_bursts));
      check("err_count", 64'(err_count), 64'(v.exp_err));
      check("first_err_addr", 64'(first_err_addr), 64'(v.exp_first));
      check("wr_addr_left", 64'(exp_wr_addr.size()), 64'h0);
      check("wdata_left", 64'(exp_wdata.size()), 64'h0);
      check("rd_addr_left", 64'(exp_rd_addr.size()), 64'h0);
      check("stall_stable", 64'(stall_viol), 64'h0);
    end
    @(negedge clk_clk);
    check("done_one_cycle", 64'(done), 64'h0);
    check("err_count_held", 64'(err_count), 64'(v.exp_err));
  endtask

  vec_t vecs[7];

  initial begin
    int    k;
    vec_t  rv;

    vecs[0] = '{27'h100, 27'd32, 0, 1, 1, -1, -1, 16'd0, 27'h0, 4, 1'b0};
    vecs[1] = '{27'h040, 27'd24, 0, 2, 4, 5, 17, 16'd2, 27'h45, 3, 1'b0};
    vecs[2] = '{27'h500, 27'd7, 0, 1, 1, -1, -1, 16'd0, 27'h0, 0, 1'b0};
    vecs[3] = '{27'h1000, 27'd64, 50, 3, 20, -1, -1, 16'd0, 27'h0, 8, 1'b1};
    vecs[4] = '{27'h600, 27'd9, 30, 3, 6, -1, -1, 16'd0, 27'h0, 1, 1'b0};
    vecs[5] = '{27'h7FF_FFF8, 27'd16, 20, 1, 5, -1, -1, 16'd0, 27'h0, 2, 1'b0};
    vecs[6] = '{27'h040, 27'd24, 50, 3, 20, 0, 23, 16'd2, 27'h40, 3, 1'b0};

    reset_reset_n = 1'b0;
    start = 1'b0; base_addr = '0; num_words = '0;
    repeat (3) @(negedge clk_clk);
    check_reset_state("reset");
    reset_reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_test(vecs[i]);
      if (i == 0) check("word0_data", mem[27'h100], 64'hA5A5_0000_5A5A_FFFF);
      if (i == 5) check("wrap_word_at_0", mem[27'h0], model_word(8));
    end

    // Reset while waiting for read beats; the remaining beats of that burst
    // (including corrupted ones) arrive while the tester sits in IDLE.
    wait_pct = 0; lat_min = 5; lat_max = 5; corrupt0 = 3; corrupt1 = 4;
    test_base = 27'h200;
    for (int b = 0; b < 2; b++) begin
      exp_wr_addr.push_back(27'h200 + addr_t'(b * BL));
      exp_rd_addr.push_back(27'h200 + addr_t'(b * BL));
    end
    for (int i = 0; i < 16; i++) exp_wdata.push_back(model_word(i));
    @(negedge clk_clk);
    start = 1'b1; base_addr = 27'h200; num_words = 27'd16;
    @(negedge clk_clk);
    start = 1'b0;
    k = 0;
    while (!(rd_left > 0 && rd_k >= 2) && k < 2000) begin
      @(negedge clk_clk);
      k++;
    end
    check("reach_rd_data_timeout", 64'(k < 2000), 64'h1);
    #2;
    reset_reset_n = 1'b0;
    #1;
    check_reset_state("midreset");
    exp_wr_addr.delete();
    exp_rd_addr.delete();
    exp_wdata.delete();
    wr_beat = 0;
    @(negedge clk_clk);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    k = 0;
    while (rd_left > 0 && k < 200) begin
      @(negedge clk_clk);
      k++;
    end
    @(negedge clk_clk);
    check("stale_err_count", 64'(err_count), 64'h0);
    check("stale_busy", 64'(busy), 64'h0);
    check("stale_read", 64'(avm_read), 64'h0);

    rv = '{27'h300, 27'd8, 0, 2, 3, -1, -1, 16'd0, 27'h0, 1, 1'b0};
    run_test(rv);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_rw_tester.md
# sdram_rw_tester

Avalon-MM master that sits directly upstream of the `soc` HPS SDRAM subsystem and drives its FPGA-to-HPS SDRAM port. On a start pulse it writes a deterministic pattern to a window of HPS DDR3 in fixed-length bursts, reads the window back, and compares each returned word. It reports an error count and the first failing address. Typical uses are board bring-up and soak testing of the HPS memory path.

## Interface
Parameters:
- `ADDR_W`, 27, Avalon word-address width. Word = 64 bits, 1 GB space.
- `BURST_LEN`, 8, beats per burst; power of two, 1..64.
- `BURST_W`, 7, width of `avm_burstcount`; must hold `BURST_LEN`.
- `SEED`, 32'hA5A5_0000, pattern seed.

Ports:
- `clk_clk`  in  1  single clock; same clock as the SDRAM port.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first word address; sampled with `start`.
- `num_words`  in  ADDR_W  window length in words; sampled with `start`.
- `busy`  out  1  test in progress.
- `done`  out  1  one-cycle pulse when the test ends.
- `err_count`  out  16  mismatching words; saturates at 16'hFFFF.
- `first_err_addr`  out  ADDR_W  word address of the first mismatch.
- `avm_address`  out  ADDR_W  burst start word address.
- `avm_burstcount`  out  BURST_W  always `BURST_LEN` while a command is active.
- `avm_write`, `avm_read`  out  1  command strobes.
- `avm_writedata`  out  64  write data.
- `avm_byteenable`  out  8  always 8'hFF.
- `avm_readdata`  in  64  read data.
- `avm_readdatavalid`  in  1  read data valid.
- `avm_waitrequest`  in  1  slave stall.

## Operation
- Pattern for word index i (0-based within the window): `v = SEED + i` (32-bit wrap). Data is `{v, ~v}`.
- Effective length: `N = num_words` rounded down to a multiple of `BURST_LEN`. `B = N / BURST_LEN` bursts.
- States:
  - IDLE: `start` goes to WR if `N != 0`. If `N == 0`, go to FIN.
  - WR: issue B write bursts back-to-back, `BURST_LEN` beats each. After the last beat is accepted, go to RD_CMD.
  - RD_CMD: assert `avm_read` for one burst. On acceptance, go to RD_DATA.
  - RD_DATA: count `BURST_LEN` valid beats. When done, go to RD_CMD if bursts remain, otherwise FIN.
  - FIN: pulse `done`, return to IDLE.
- Read bursts are strictly one outstanding: the next read command is issued only after all beats of the previous burst have arrived.
- Compare every valid beat against the pattern for its index.
  - On a mismatch, `err_count` increments (saturating).
  - On the first mismatch of a test, `first_err_addr` is captured.
- `err_count` and `first_err_addr` clear when a new test is accepted from IDLE. They hold their values after `done`.
- Address arithmetic is modulo 2^ADDR_W. A window that crosses the top of the address space wraps to 0 with no error.

## Timing
- Reset values:
  - `busy`, `done`, `avm_write`, `avm_read`: 0.
  - `err_count`, `first_err_addr`, `avm_address`, `avm_writedata`: 0.
  - `avm_burstcount`: `BURST_LEN`. `avm_byteenable`: 8'hFF.
- `busy` rises the cycle after `start` is accepted. It falls in the same cycle that `done` pulses.
- Start with `N == 0`: `done` pulses 2 cycles after `start`, with no bus activity.
- Avalon handshake: a beat or command is accepted on a rising edge when the strobe is high and `avm_waitrequest` is low.
  - While stalled, address, burstcount and data hold stable.
- Write bursts:
  - `avm_address` and `avm_burstcount` are valid on the first beat of each burst.
  - `avm_write` may stay high across burst boundaries. There are no idle cycles when there is no wait.
  - Minimum write phase: N cycles.
- `avm_read` is high for exactly one accepted cycle per burst.
- Compare is registered: `err_count` updates 1 cycle after the mismatching beat.
  - `done` is issued only after the final compare has been registered.
- `start` while busy is ignored.
- Reset mid-test: strobes drop asynchronously. The next test must be started from IDLE. Late `avm_readdatavalid` beats received while in IDLE are ignored.

## Structure
- Package `sdram_rw_pkg` holds:
  - the state enum (IDLE, WR, RD_CMD, RD_DATA, FIN);
  - the `pattern(idx)` function;
  - the `DATA_W = 64` and `BE_ALL = 8'hFF` constants.
- Sub-module `sdram_rw_checker`:
  - inputs: beat valid, read data, and a beat index counter;
  - outputs: registered `err_count` and `first_err_addr`;
  - includes a clear input.
- The top level holds the FSM, burst and beat counters, and the address generator.

## Test plan
- Clean run: base 0x100, num_words 32, BURST_LEN 8, ideal slave.
  - Expect 4 write bursts at addresses 0x100, 0x108, 0x110, 0x118, then 4 read bursts.
  - `err_count` = 0; `done` pulses once; word 0 data = 64'hA5A5_0000_5A5A_FFFF.
- Backpressure: random `avm_waitrequest` at 50% and read latency of 3–20 cycles.
  - Writedata and address stay stable under stall; `err_count` = 0.
- Injected faults: the slave corrupts words 5 and 17 of a 24-word window at base 0x40.
  - `err_count` = 2; `first_err_addr` = 0x45.
- Length edges:
  - `num_words` 7 → no bus traffic, `done` 2 cycles after `start`.
  - `num_words` 9 → exactly 1 burst.
- Wrap: base 2^27−8, 16 words → the second burst is at address 0; `err_count` = 0.
- Reset in RD_DATA → all outputs return to reset values. A following 8-word test completes with `err_count` = 0, and stale beats are ignored.
